// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, STABLE/SETTLING filter, registered level and change pulse.
// Output updates 3 cycles after the input plus STABLE_TICKS ticks of steady level; there is no backpressure.
module debounce_bit #(
    parameter int   STABLE_TICKS = 10,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    input  logic tick,
    output logic sw,
    output logic changed
);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    localparam logic ENC_STABLE   = 1'b0;
    localparam logic ENC_SETTLING = 1'b1;

    typedef enum logic {
        STABLE   = ENC_STABLE,
        SETTLING = ENC_SETTLING
    } state_t;

    logic          meta;
    logic          sync;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sw_n;
    logic          changed_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta    <= RST_VAL;
            sync    <= RST_VAL;
            state   <= STABLE;
            cnt     <= '0;
            sw      <= RST_VAL;
            changed <= 1'b0;
        end else begin
            meta    <= sw_raw;
            sync    <= meta;
            state   <= state_n;
            cnt     <= cnt_n;
            sw      <= sw_n;
            changed <= changed_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sw_n      = sw;
        changed_n = 1'b0;
        case (state)
            STABLE: begin
                if (sync != sw) begin
                    state_n = SETTLING;
                    cnt_n   = '0;
                end
            end
            SETTLING: begin
                if (sync == sw) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (tick) begin
                    // The tick that would bring cnt to STABLE_TICKS accepts the new level instead.
                    if (cnt == CNT_LAST) begin
                        state_n   = STABLE;
                        cnt_n     = '0;
                        sw_n      = sync;
                        changed_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: rtl/gpio_debounce.sv
// Debounces WIDTH board switches, keeps sticky per-bit change flags (write-1-to-clear) and an IRQ.
// o_sw settles 3+(STABLE_TICKS-1)*TICK_DIV..3+STABLE_TICKS*TICK_DIV cycles after a steady change; there is no backpressure.
module gpio_debounce #(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_changed,
    output logic [WIDTH-1:0] o_edges,
    input  logic [WIDTH-1:0] i_ack,
    output logic             o_irq
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;

    // With TICK_DIV=1 the counter sits at zero and tick is asserted every cycle.
    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS),
            .RST_VAL     (RESET_VAL[g])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .sw_raw (i_sw[g]),
            .tick   (tick),
            .sw     (o_sw[g]),
            .changed(o_changed[g])
        );
    end

    // A new change outranks an acknowledge arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_edges <= '0;
        end else begin
            o_edges <= (o_edges & ~i_ack) | o_changed;
        end
    end

    assign o_irq = |o_edges;
endmodule
